writeback_unit: RTL and testbench

Write-side partner of the register bank: collects destination results from the ALU path, the memory-load path and the link (call) path, buffers them in a small in-order FIFO, and drives the bank's single write port (RD, WB, WE) one entry per cycle. It also exports a per-register pending-write mask so decode can stall on read-after-write hazards until the bank actually holds the value.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 74 +++++++
 rtl/writeback_unit.sv | 112 +++++++++++
 tb/tb_writeback_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback unit.
//   BUS      : data width of a register write
//   DIR      : register address width (2**DIR registers)
//   LINK_REG : default destination register for link (call) writes
package wb_pkg;
    localparam int BUS      = 32;
    localparam int DIR      = 4;
    localparam int NREG     = 2 ** DIR;
    localparam int LINK_REG = 14;

    typedef struct packed {
        logic [DIR-1:0] rd;
        logic [BUS-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_LNK,
        SRC_MEM,
        SRC_ALU
    } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// In-order circular FIFO of pending register writes.
//   clk, rst     : clock, async active-high reset
//   push_i/din_i : enqueue one entry (ignored when full)
//   pop_i/dout_o : dequeue head (ignored when empty); dout_o is the current head
//   full_o, empty_o, count_o : occupancy
//   vld_o, rd_o  : per-slot valid flag and destination, for hazard tracking
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  wb_entry_t                     din_i,
    input  logic                          pop_i,
    output wb_entry_t                     dout_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic [DEPTH-1:0]              vld_o,
    output logic [DEPTH-1:0][DIR-1:0]     rd_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer increments wrap for free.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + CW'(1);
        if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: slots are only observed through vld_o/count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            vld_o[i] = (CW'(PW'(i) - rd_ptr_q) < count_q);
            rd_o[i]  = mem_q[i].rd;
        end
    end
endmodule

// File: rtl/writeback_unit.sv
// Collects results from the link, load and ALU paths, buffers them in order,
// and drives the register bank write port one entry per cycle.
//   clk, rst                        : clock, async active-high reset
//   alu_*_i / alu_ready_o           : ALU result offer/accept
//   mem_*_i / mem_ready_o           : load result offer/accept
//   lnk_valid_i, lnk_pc_i / lnk_ready_o : link write offer/accept (to LINK_REG)
//   rd_o, wb_o, we_o                : registered bank write port
//   busy_mask_o                     : registers with a write still pending
//   count_o                         : entries buffered
module writeback_unit #(
    parameter int DEPTH    = 4,
    parameter int LINK_REG = wb_pkg::LINK_REG
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid_i,
    input  logic [wb_pkg::DIR-1:0]        alu_rd_i,
    input  logic [wb_pkg::BUS-1:0]        alu_data_i,
    output logic                          alu_ready_o,
    input  logic                          mem_valid_i,
    input  logic [wb_pkg::DIR-1:0]        mem_rd_i,
    input  logic [wb_pkg::BUS-1:0]        mem_data_i,
    output logic                          mem_ready_o,
    input  logic                          lnk_valid_i,
    input  logic [wb_pkg::BUS-1:0]        lnk_pc_i,
    output logic                          lnk_ready_o,
    output logic [wb_pkg::DIR-1:0]        rd_o,
    output logic [wb_pkg::BUS-1:0]        wb_o,
    output logic                          we_o,
    output logic [wb_pkg::NREG-1:0]       busy_mask_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);
    import wb_pkg::*;

    wb_src_e                  src;
    wb_entry_t                din, dout;
    logic                     full, empty, push, pop;
    logic [DEPTH-1:0]         slot_vld;
    logic [DEPTH-1:0][DIR-1:0] slot_rd;

    logic [DIR-1:0]           rd_q;
    logic [BUS-1:0]           wb_q;
    logic                     we_q;

    // Fixed priority lnk > mem > alu; nothing is accepted while full, even if
    // the head drains on the same edge.
    always_comb begin
        src = SRC_NONE;
        din = '0;
        if (!full) begin
            if (lnk_valid_i) begin
                src = SRC_LNK;
                din = '{rd: DIR'(LINK_REG), data: lnk_pc_i};
            end else if (mem_valid_i) begin
                src = SRC_MEM;
                din = '{rd: mem_rd_i, data: mem_data_i};
            end else if (alu_valid_i) begin
                src = SRC_ALU;
                din = '{rd: alu_rd_i, data: alu_data_i};
            end
        end
    end

    assign lnk_ready_o = (src == SRC_LNK);
    assign mem_ready_o = (src == SRC_MEM);
    assign alu_ready_o = (src == SRC_ALU);
    assign push        = (src != SRC_NONE);
    assign pop         = !empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (pop),
        .dout_o  (dout),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o),
        .vld_o   (slot_vld),
        .rd_o    (slot_rd)
    );

    // Output register: RD/WB hold their last value when nothing drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
            wb_q <= '0;
            we_q <= 1'b0;
        end else begin
            we_q <= pop;
            if (pop) begin
                rd_q <= dout.rd;
                wb_q <= dout.data;
            end
        end
    end

    assign rd_o = rd_q;
    assign wb_o = wb_q;
    assign we_o = we_q;

    // The entry on the write port still counts as pending until the bank
    // has taken it.
    always_comb begin
        busy_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i]) busy_mask_o[slot_rd[i]] = 1'b1;
        end
        if (we_q) busy_mask_o[rd_q] = 1'b1;
    end
endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 0, mem_valid = 0, lnk_valid = 0;
    logic [3:0]  alu_rd = 0, mem_rd = 0;
    logic [31:0] alu_data = 0, mem_data = 0, lnk_pc = 0;
    logic        alu_ready, mem_ready, lnk_ready;
    logic [3:0]  rd;
    logic [31:0] wb;
    logic        we;
    logic [15:0] busy_mask;
    logic [2:0]  count;

    writeback_unit #(.DEPTH(DEPTH), .LINK_REG(14)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
        .mem_valid_i(mem_valid), .mem_rd_i(mem_rd), .mem_data_i(mem_data), .mem_ready_o(mem_ready),
        .lnk_valid_i(lnk_valid), .lnk_pc_i(lnk_pc), .lnk_ready_o(lnk_ready),
        .rd_o(rd), .wb_o(wb), .we_o(we), .busy_mask_o(busy_mask), .count_o(count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: accepted-but-unwritten entries, plus the write port.
    typedef struct { logic [3:0] rd; logic [31:0] d; } ent_t;
    ent_t q[$];
    ent_t bus = '{rd: 4'd0, d: 32'd0};
    bit   bus_we = 0;
    ent_t obs[$];   // writes seen on the port, in order

    function automatic logic [15:0] model_busy();
        logic [15:0] m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        if (bus_we) m[bus.rd] = 1'b1;
        return m;
    endfunction

    // One clock cycle: drive offers at the falling edge, check ready, advance
    // the model across the rising edge, then check the registered outputs.
    task automatic cycle(input bit av, input logic [3:0] ar, input logic [31:0] ad,
                         input bit mv, input logic [3:0] mr, input logic [31:0] md,
                         input bit lv, input logic [31:0] lp);
        bit   full, el, em, ea, acc;
        ent_t e;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        lnk_valid = lv; lnk_pc = lp;
        #1;
        full = (q.size() >= DEPTH);
        el = lv && !full;
        em = mv && !lv && !full;
        ea = av && !mv && !lv && !full;
        tests++; if (lnk_ready !== el) begin fails++; $display("FAIL lnk_ready: got %b expected %b", lnk_ready, el); end
        tests++; if (mem_ready !== em) begin fails++; $display("FAIL mem_ready: got %b expected %b", mem_ready, em); end
        tests++; if (alu_ready !== ea) begin fails++; $display("FAIL alu_ready: got %b expected %b", alu_ready, ea); end
        acc = el || em || ea;
        e = el ? '{rd: 4'd14, d: lp} : em ? '{rd: mr, d: md} : '{rd: ar, d: ad};
        if (q.size() > 0) begin bus = q.pop_front(); bus_we = 1; end
        else bus_we = 0;
        if (acc) q.push_back(e);
        @(posedge clk); @(negedge clk);
        tests++; if (we !== bus_we) begin fails++; $display("FAIL we: got %b expected %b", we, bus_we); end
        tests++; if (rd !== bus.rd) begin fails++; $display("FAIL rd: got %0d expected %0d", rd, bus.rd); end
        tests++; if (wb !== bus.d) begin fails++; $display("FAIL wb: got %h expected %h", wb, bus.d); end
        tests++; if (count !== 3'(q.size())) begin fails++; $display("FAIL count: got %0d expected %0d", count, q.size()); end
        tests++; if (busy_mask !== model_busy()) begin fails++; $display("FAIL busy_mask: got %h expected %h", busy_mask, model_busy()); end
        if (we === 1'b1) obs.push_back('{rd: rd, d: wb});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        tests++; if ({we, rd, wb, count, busy_mask} !== '0) begin
            fails++; $display("FAIL reset_state: got we=%b rd=%0d wb=%h count=%0d busy=%h expected all zero", we, rd, wb, count, busy_mask);
        end
        @(negedge clk); @(negedge clk);
        rst = 0;
        idle(1);
    endtask

    task automatic test_single_alu();
        obs.delete();
        cycle(1, 4'd3, 32'hAA, 0, 0, 0, 0, 0);
        tests++; if (busy_mask[3] !== 1'b1 || we !== 1'b0) begin
            fails++; $display("FAIL single_accept: got busy3=%b we=%b expected 1 0", busy_mask[3], we);
        end
        idle(1);
        tests++; if (we !== 1'b1 || rd !== 4'd3 || wb !== 32'hAA || busy_mask[3] !== 1'b1) begin
            fails++; $display("FAIL single_write: got we=%b rd=%0d wb=%h busy3=%b expected 1 3 000000aa 1", we, rd, wb, busy_mask[3]);
        end
        idle(1);
        tests++; if (we !== 1'b0 || busy_mask !== 16'h0) begin
            fails++; $display("FAIL single_done: got we=%b busy=%h expected 0 0000", we, busy_mask);
        end
        tests++; if (obs.size() != 1) begin fails++; $display("FAIL single_count: got %0d writes expected 1", obs.size()); end
    endtask

    task automatic test_priority();
        bit pa = 1, pm = 1, pl = 1;
        obs.delete();
        for (int i = 0; i < 3; i++) begin
            bit gl = pl, gm = pm && !pl, ga = pa && !pm && !pl;
            cycle(pa, 4'd1, 32'hA1, pm, 4'd2, 32'hB2, pl, 32'h100);
            if (gl) pl = 0; else if (gm) pm = 0; else if (ga) pa = 0;
        end
        idle(3);
        tests++; if (obs.size() != 3) begin fails++; $display("FAIL prio_count: got %0d expected 3", obs.size()); end
        else begin
            tests++; if (obs[0].rd !== 4'd14 || obs[0].d !== 32'h100) begin fails++; $display("FAIL prio_first: got rd=%0d wb=%h expected 14 00000100", obs[0].rd, obs[0].d); end
            tests++; if (obs[1].rd !== 4'd2 || obs[1].d !== 32'hB2) begin fails++; $display("FAIL prio_second: got rd=%0d wb=%h expected 2 000000b2", obs[1].rd, obs[1].d); end
            tests++; if (obs[2].rd !== 4'd1 || obs[2].d !== 32'hA1) begin fails++; $display("FAIL prio_third: got rd=%0d wb=%h expected 1 000000a1", obs[2].rd, obs[2].d); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[6];
        obs.delete();
        for (int i = 0; i < 6; i++) begin
            vals[i] = $urandom;
            cycle(1, 4'(i + 7), vals[i], 0, 0, 0, 0, 0);
            tests++; if (count > 3'(DEPTH)) begin fails++; $display("FAIL b2b_bound: got count=%0d expected <= %0d", count, DEPTH); end
        end
        idle(3);
        tests++; if (obs.size() != 6) begin fails++; $display("FAIL b2b_count: got %0d expected 6", obs.size()); end
        else for (int i = 0; i < 6; i++) begin
            tests++; if (obs[i].rd !== 4'(i + 7) || obs[i].d !== vals[i]) begin
                fails++; $display("FAIL b2b_order[%0d]: got rd=%0d wb=%h expected %0d %h", i, obs[i].rd, obs[i].d, i + 7, vals[i]);
            end
        end
    endtask

    task automatic test_same_reg();
        obs.delete();
        cycle(1, 4'd5, 32'h11, 0, 0, 0, 0, 0);
        cycle(1, 4'd5, 32'h22, 0, 0, 0, 0, 0);
        idle(1);
        tests++; if (busy_mask[5] !== 1'b1) begin fails++; $display("FAIL same_busy_held: got %b expected 1", busy_mask[5]); end
        idle(2);
        tests++; if (busy_mask[5] !== 1'b0) begin fails++; $display("FAIL same_busy_clear: got %b expected 0", busy_mask[5]); end
        tests++; if (obs.size() != 2 || obs[1].d !== 32'h22 || obs[0].d !== 32'h11) begin
            fails++; $display("FAIL same_reg_writes: got %0d writes expected 2 ending with 00000022", obs.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        obs.delete();
        cycle(0, 0, 0, 1, 4'd9, 32'h9, 1, 32'h200);
        cycle(0, 0, 0, 1, 4'd9, 32'h9, 0, 0);
        cycle(1, 4'd4, 32'h4, 0, 0, 0, 0, 0);
        // Mid-cycle asynchronous reset while the port is busy.
        #2 rst = 1;
        #1;
        tests++; if ({we, rd, wb, count, busy_mask} !== '0) begin
            fails++; $display("FAIL rst_mid_drain: got we=%b rd=%0d wb=%h count=%0d busy=%h expected all zero", we, rd, wb, count, busy_mask);
        end
        q.delete(); bus_we = 0; bus = '{rd: 4'd0, d: 32'd0};
        @(negedge clk); @(negedge clk);
        rst = 0;
        obs.delete();
        idle(4);
        tests++; if (obs.size() != 0) begin fails++; $display("FAIL rst_no_writes: got %0d writes expected 0", obs.size()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 1), 4'($urandom), $urandom,
                  $urandom_range(0, 3) == 0, 4'($urandom), $urandom,
                  $urandom_range(0, 7) == 0, $urandom);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_priority();
        test_back_to_back();
        test_same_reg();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
